// File: rtl/coin_seq_pkg.sv
// coin_seq_pkg: state encoding and Ca status codes shared by the coin sequence initiator
package coin_seq_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_COIN1  = 3'd1;
    localparam logic [2:0] S_INSERT = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_COIN2  = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;
    localparam logic [1:0] CA_IDLE   = 2'b00;
    localparam logic [1:0] CA_FIRST  = 2'b01;
    localparam logic [1:0] CA_SECOND = 2'b10;
    localparam logic [1:0] CA_DONE   = 2'b11;
endpackage

// File: rtl/coin_seq_timer.sv
// coin_seq_timer: CNT_W-bit down-counter (ld/ld_val load, dec enable, saturates at zero, zero flag out)
module coin_seq_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic             dec,
    input  logic [CNT_W-1:0] ld_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    assign zero = cnt == '0;
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (ld) cnt <= ld_val;
        else if (dec && !zero) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/coin_seq_driver.sv
// coin_seq_driver: drives c1/c2/i strobes then waits for Ca==11 (ports clk reset start order ca_in -> c1_out c2_out i_out busy done timeout_err result_ca; abort input when COIN_SEQ_ABORT_EN)
module coin_seq_driver
    import coin_seq_pkg::*;
#(
    parameter int PULSE_LEN = 2,
    parameter int GAP_CYC   = 1,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       order,
`ifdef COIN_SEQ_ABORT_EN
    input  logic       abort,
`endif
    input  logic [1:0] ca_in,
    output logic       c1_out,
    output logic       c2_out,
    output logic       i_out,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic [1:0] result_ca
);
    localparam logic             HAS_GAP = GAP_CYC > 0;
    localparam logic [CNT_W-1:0] PL = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GL = CNT_W'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] TL = CNT_W'(TIMEOUT - 1);
    logic [2:0]       state, nxt;
    logic             ord, ld, zero;
    logic [CNT_W-1:0] ld_val;
    coin_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk(clk), .reset(reset), .ld(ld), .dec(!ld), .ld_val(ld_val), .zero(zero)
    );
    always_comb begin
        nxt    = state;
        ld     = 1'b0;
        ld_val = PL;
        case (state)
            S_IDLE:   begin nxt = start ? S_COIN1 : S_IDLE; ld = start; end
            S_COIN1:  nxt = zero ? S_INSERT : S_COIN1;
            S_INSERT: begin nxt = HAS_GAP ? S_GAP : S_COIN2; ld = 1'b1; ld_val = HAS_GAP ? GL : PL; end
            S_GAP:    begin nxt = zero ? S_COIN2 : S_GAP; ld = zero; end
            S_COIN2:  begin nxt = zero ? S_WAIT : S_COIN2; ld = zero; ld_val = TL; end
            S_WAIT:   nxt = ca_in == CA_DONE ? S_DONE : zero ? S_ERR : S_WAIT;
            default:  nxt = S_IDLE;
        endcase
`ifdef COIN_SEQ_ABORT_EN
        if (abort && state != S_IDLE) begin
            nxt = S_IDLE;
            ld  = 1'b0;
        end
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ord       <= 1'b0;
            result_ca <= CA_IDLE;
        end else begin
            state <= nxt;
            if (state == S_IDLE && start) ord <= order;
            if (nxt == S_DONE || nxt == S_ERR) result_ca <= ca_in;
        end
    end
    assign c1_out      = (state == S_COIN1 && !ord) || (state == S_COIN2 && ord);
    assign c2_out      = (state == S_COIN1 && ord) || (state == S_COIN2 && !ord);
    assign i_out       = state == S_INSERT;
    assign busy        = state != S_IDLE;
    assign done        = state == S_DONE;
    assign timeout_err = state == S_ERR;
endmodule

// File: tb/tb_coin_seq_driver.sv
// tb_coin_seq_driver: vector table, directed corner sequences and random stimulus against a cycle-count reference model
module tb_coin_seq_driver;
    localparam int P = 2, T = 16;
    logic clk = 0, reset = 1, start = 0, order = 0, abort = 0;
    logic [1:0] ca_in = 0;
    wire [7:0] o0, o1;
    int errors = 0, checks = 0;
    bit mon = 0;
    always #5 clk = ~clk;
    coin_seq_driver #(.PULSE_LEN(P), .GAP_CYC(1), .TIMEOUT(T), .CNT_W(5)) u0 (
        .clk(clk), .reset(reset), .start(start), .order(order),
`ifdef COIN_SEQ_ABORT_EN
        .abort(abort),
`endif
        .ca_in(ca_in), .c1_out(o0[7]), .c2_out(o0[6]), .i_out(o0[5]), .busy(o0[4]),
        .done(o0[3]), .timeout_err(o0[2]), .result_ca(o0[1:0])
    );
    coin_seq_driver #(.PULSE_LEN(P), .GAP_CYC(0), .TIMEOUT(T), .CNT_W(5)) u1 (
        .clk(clk), .reset(reset), .start(start), .order(order),
`ifdef COIN_SEQ_ABORT_EN
        .abort(abort),
`endif
        .ca_in(ca_in), .c1_out(o1[7]), .c2_out(o1[6]), .i_out(o1[5]), .busy(o1[4]),
        .done(o1[3]), .timeout_err(o1[2]), .result_ca(o1[1:0])
    );
    typedef struct {bit act; int k; bit ord; int fin; logic [1:0] res;} m_t;
    m_t m0, m1;
    function automatic m_t step(m_t m, int g);
        int w0;
        w0 = 2 * P + 2 + g;
        if (reset) begin
            m.act = 0; m.k = 0; m.ord = 0; m.fin = 0; m.res = 2'b00;
            return m;
        end
`ifdef COIN_SEQ_ABORT_EN
        if (abort && m.act) begin
            m.act = 0; m.fin = 0;
            return m;
        end
`endif
        if (!m.act) begin
            if (start) begin m.act = 1; m.k = 1; m.ord = order; m.fin = 0; end
        end else if (m.fin != 0) begin
            m.act = 0; m.fin = 0;
        end else if (m.k >= w0 && ca_in == 2'b11) begin
            m.fin = 1; m.res = ca_in;
        end else if (m.k >= w0 && m.k - w0 == T - 1) begin
            m.fin = 2; m.res = ca_in;
        end else m.k++;
        return m;
    endfunction
    function automatic logic [7:0] expv(m_t m, int g);
        bit run, f, s;
        run = m.act && m.fin == 0;
        f = run && m.k >= 1 && m.k <= P;
        s = run && m.k >= P + 2 + g && m.k <= 2 * P + 1 + g;
        return {(f && !m.ord) || (s && m.ord), (f && m.ord) || (s && !m.ord), run && m.k == P + 1,
                m.act, m.act && m.fin == 1, m.act && m.fin == 2, m.res};
    endfunction
    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", n, a, e, $time);
        end
    endtask
    always @(posedge clk) begin
        m0 = step(m0, 1);
        m1 = step(m1, 0);
    end
    always @(negedge clk) if (mon) begin
        chk("model_gap1", o0, expv(m0, 1));
        chk("model_gap0", o1, expv(m1, 0));
    end
    task automatic tick(input logic st, input logic od = 0, input logic [1:0] ca = 0,
                        input logic rs = 0, input logic ab = 0);
        @(posedge clk);
        #1;
        start = st; order = od; ca_in = ca; reset = rs; abort = ab;
        @(negedge clk);
    endtask
    typedef struct {logic st; logic [1:0] ca; logic [7:0] exp;} vec_t;
    vec_t tbl[12];
    initial begin
        tbl[0]  = '{1'b1, 2'b00, 8'b0000_0000};
        tbl[1]  = '{1'b0, 2'b00, 8'b1001_0000};
        tbl[2]  = '{1'b0, 2'b00, 8'b1001_0000};
        tbl[3]  = '{1'b0, 2'b00, 8'b0011_0000};
        tbl[4]  = '{1'b0, 2'b00, 8'b0001_0000};
        tbl[5]  = '{1'b0, 2'b00, 8'b0101_0000};
        tbl[6]  = '{1'b0, 2'b00, 8'b0101_0000};
        tbl[7]  = '{1'b0, 2'b00, 8'b0001_0000};
        tbl[8]  = '{1'b0, 2'b00, 8'b0001_0000};
        tbl[9]  = '{1'b0, 2'b11, 8'b0001_0000};
        tbl[10] = '{1'b0, 2'b00, 8'b0001_1011};
        tbl[11] = '{1'b0, 2'b00, 8'b0000_0011};
        repeat (3) @(posedge clk);
        #1 reset = 0;
        mon = 1;
        @(negedge clk);
        chk("reset_state", o0, 8'h00);
        for (int n = 0; n < 12; n++) begin
            tick(tbl[n].st, 1'b0, tbl[n].ca);
            chk($sformatf("table_c%0d", n), o0, tbl[n].exp);
        end
        for (int c = 0; c < 11; c++) begin
            tick(c == 0, 1'b1, c == 8 ? 2'b11 : 2'b00);
            if (c < 8) chk($sformatf("ord1_gap0_c%0d", c), {4'b0, o1[7:4]},
                {4'b0, c == 0 ? 4'b0000 : c < 3 ? 4'b0101 : c == 3 ? 4'b0011 : c < 6 ? 4'b1001 : 4'b0001});
        end
        for (int c = 0; c < 25; c++) begin
            tick(c == 0, 1'b0, 2'b01);
            if (c == 22) chk("to_last_wait", {5'b0, o0[4:2]}, 8'b100);
            if (c == 23) chk("to_err", {4'b0, o0[3:0]}, 8'b0101);
            if (c == 24) chk("to_idle", {7'b0, o0[4]}, 8'b0);
        end
        for (int c = 0; c < 25; c++) begin
            tick(c == 0 || (c >= 2 && c <= 8), 1'b0, c == 22 ? 2'b11 : 2'b00);
            if (c == 23) chk("late_done", {4'b0, o0[3:0]}, 8'b1011);
            if (c == 24) chk("no_relaunch", {7'b0, o0[4]}, 8'b0);
        end
        for (int c = 0; c < 21; c++) begin
            tick(c == 0 || c == 8, 1'b0, c == 16 ? 2'b11 : 2'b00, c == 5);
            if (c == 5) chk("c2_before_rst", {7'b0, o0[6]}, 8'b1);
            if (c == 6) chk("rst_abort", {6'b0, o0[6], o0[4]}, 8'b0);
            if (c == 9) chk("restart_c1", {7'b0, o0[7]}, 8'b1);
            if (c == 17) chk("restart_done", {4'b0, o0[3:0]}, 8'b1011);
        end
`ifdef COIN_SEQ_ABORT_EN
        for (int c = 0; c < 6; c++) begin
            tick(c == 0, 1'b0, 2'b00, 1'b0, c == 3);
            if (c == 3) chk("abort_in_insert", {7'b0, o0[5]}, 8'b1);
            if (c == 4) chk("abort_idle", o0, 8'b0000_0011);
        end
`endif
        for (int c = 0; c < 800; c++)
            tick($urandom % 4 == 0, 1'($urandom), $urandom % 6 == 0 ? 2'b11 : 2'($urandom % 3),
                 $urandom % 80 == 0, $urandom % 50 == 0);
        mon = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
